if_id_stage: RTL and testbench
==============================

Name: if_id_stage

Overview:
- Fetch stage plus IF/ID pipeline register of the 5-stage MIPS core. It sits directly upstream of the ID/EX buffer.
- Owns the 8-bit PC and drives the instruction-memory address. It latches PC+4 and the fetched instruction for decode.
- Detects load-use hazards against the instruction currently in ID/EX, and handles branch/jump redirects (flush).
- Produces the bubble request that zeroes the M/EX/WB control bundles before they enter ID/EX.

Parameters:
- PC_W, 8, PC / instruction-memory byte-address width (matches the nextInst field width).
- CNT_W, 16, width of the saturating stall and flush event counters.

Ports:
- clk_if_id  input  1  rising-edge clock.
- rst_if_id  input  1  asynchronous, active-high reset.
- imem_addr_IF  output  PC_W  instruction-memory byte address; equals pc_IF.
- imem_data_IF  input  32  instruction word; combinational read of imem_addr_IF.
- redirect_IF  input  1  branch taken or jump resolved downstream; flush request.
- redirect_pc_IF  input  PC_W  redirect target address.
- idex_memread_IF  input  1  MemRead bit of the instruction currently in ID/EX.
- idex_rt_IF  input  5  rt field of the instruction currently in ID/EX.
- pc_IF  output  PC_W  current PC register.
- nextInst_IFID  output  PC_W  latched PC+4 of the decode instruction.
- inst_IFID  output  32  latched instruction word.
- valid_IFID  output  1  the IF/ID contents are a real instruction.
- bubble_IFID  output  1  combinational; control unit must force M/EX/WB to 0 this cycle.
- stall_cnt  output  CNT_W  saturating count of load-use stall cycles.
- flush_cnt  output  CNT_W  saturating count of redirect cycles.

Behaviour:
- Reset (async, immediate) sets pc_IF=0, nextInst_IFID=0, inst_IFID=0, valid_IFID=0, both counters=0, FSM=RUN. bubble_IFID is 0 while in reset.
- Hazard (combinational) is true when all of the following hold:
  - valid_IFID=1;
  - idex_memread_IF=1;
  - idex_rt_IF != 0;
  - idex_rt_IF equals inst_IFID[25:21] or inst_IFID[20:16].
- stall = hazard AND state==RUN AND NOT redirect_IF.
- bubble_IFID = stall OR redirect_IF.
- FSM states:
  - RUN: normal operation. Goes to STALLED on a stall edge.
  - STALLED: one hold cycle has already been taken. Hazard is ignored in this state. Always returns to RUN on the next edge.
  - A redirect in either state goes to RUN.
- Per rising edge, in priority order:
  1. redirect_IF=1:
     - pc_IF <= {redirect_pc_IF[PC_W-1:2], 2'b00};
     - inst_IFID <= 0, nextInst_IFID <= 0, valid_IFID <= 0;
     - flush_cnt increments.
  2. stall:
     - pc_IF, nextInst_IFID, inst_IFID and valid_IFID hold;
     - stall_cnt increments.
  3. Otherwise:
     - pc_IF <= pc_IF+4 (mod 2^PC_W, wraps 252 -> 0 for PC_W=8);
     - nextInst_IFID <= pc_IF+4 (same wrap);
     - inst_IFID <= imem_data_IF;
     - valid_IFID <= 1.
- Fetch-to-decode latency is 1 cycle. Redirect-to-first-new-instruction-in-IF/ID is 1 cycle after the redirect edge.
- Counters saturate at all-ones and never wrap.
- Redirect and hazard in the same cycle: redirect wins, no stall is counted, and the FSM goes to RUN.
- Reset asserted mid-stall or mid-redirect: all state returns to reset values with no partial update.

Decomposition:
- Shared package mips_pkg holds the constants below. ID/EX and the control unit reuse them.
  - PC_W = 8.
  - OPC/RS/RT field bit positions: RS = 25:21, RT = 20:16.
  - NOP = 32'h0.
  - The FSM state enum {RUN, STALLED}.
- One sub-module is natural: hazard_detect. It is purely combinational. Inputs: valid, memread, idex_rt, inst rs/rt. Output: hazard.
- The counters are a tiny repeated pattern and stay inline.

Test Plan:
- Reset then straight-line fetch: mem[0]=32'h20080005, mem[4]=32'h20090003. After the 1st edge, inst_IFID=20080005, nextInst_IFID=4, valid=1. After the 2nd edge, inst=20090003, nextInst=8, pc_IF=8.
- Load-use: inst_IFID=32'h01095020 (rs=8, rt=9), idex_memread=1, idex_rt=9.
  - Expect bubble_IFID=1 for exactly one cycle with pc_IF and inst_IFID unchanged, stall_cnt=1.
  - The next cycle proceeds even if the inputs stay asserted (STALLED guard).
- Zero-register guard: same as the load-use case but idex_rt=0 and the instruction's rt=0. Expect no stall, bubble_IFID=0, stall_cnt=0.
- Redirect: redirect_IF=1 with redirect_pc=8'h43. Expect pc_IF=8'h40, valid_IFID=0, inst_IFID=0, flush_cnt=1. On the next edge, inst_IFID=mem[0x40] and nextInst_IFID=8'h44.
- Redirect coincident with a load-use hazard: redirect wins. flush_cnt+1, stall_cnt unchanged, pc_IF=target.
- Wrap and reset: at pc_IF=252 the next edge gives pc_IF=0 and nextInst_IFID=0. Asserting rst_if_id asynchronously mid-cycle clears all outputs immediately; the counters preset near all-ones saturate at 16'hFFFF.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: PC width, instruction field positions, NOP word, fetch FSM states.
// No logic; pure declarations.
// Reused by the fetch, ID/EX and control blocks.
package mips_pkg;

  localparam int PC_W = 8;

  // Register-specifier field positions inside an instruction word
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef enum logic {
    RUN     = 1'b0,
    STALLED = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector between the decode instruction and the load in ID/EX.
// Latency: purely combinational.
// Backpressure: none; the hazard output is what the fetch stage uses to hold itself.
module hazard_detect (
  input  logic       valid,
  input  logic       memread,
  input  logic [4:0] idex_rt,
  input  logic [4:0] inst_rs,
  input  logic [4:0] inst_rt,
  output logic       hazard
);

  // A load targeting $zero never creates a dependency, so rt==0 is excluded
  always_comb begin
    hazard = valid && memread && (idex_rt != 5'd0) &&
             ((idex_rt == inst_rs) || (idex_rt == inst_rt));
  end

endmodule

// File: rtl/if_id_stage.sv
// Fetch stage and IF/ID register: owns the PC, latches PC+4 and the fetched word for decode.
// Latency: 1 cycle fetch-to-decode; 1 cycle redirect-edge to first new instruction.
// Backpressure: a load-use hazard holds PC and IF/ID for exactly one cycle; redirect flushes and wins.
module if_id_stage
  import mips_pkg::*;
#(
  parameter int PC_W  = mips_pkg::PC_W,
  parameter int CNT_W = 16
) (
  input  logic             clk_if_id,
  input  logic             rst_if_id,
  output logic [PC_W-1:0]  imem_addr_IF,
  input  logic [31:0]      imem_data_IF,
  input  logic             redirect_IF,
  input  logic [PC_W-1:0]  redirect_pc_IF,
  input  logic             idex_memread_IF,
  input  logic [4:0]       idex_rt_IF,
  output logic [PC_W-1:0]  pc_IF,
  output logic [PC_W-1:0]  nextInst_IFID,
  output logic [31:0]      inst_IFID,
  output logic             valid_IFID,
  output logic             bubble_IFID,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  fetch_state_t    state, state_nxt;
  logic            hazard;
  logic            stall;
  logic [PC_W-1:0] pc_plus4;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  // Redirect targets are word aligned; the low address bits are dropped on purpose
  logic            redirect_lsb_unused;

  assign redirect_lsb_unused = ^redirect_pc_IF[1:0];
  assign imem_addr_IF        = pc_IF;
  assign pc_plus4            = pc_IF + PC_W'(4);
  assign stall_cnt           = stall_cnt_q;
  assign flush_cnt           = flush_cnt_q;

  hazard_detect u_hazard_detect (
    .valid   (valid_IFID),
    .memread (idex_memread_IF),
    .idex_rt (idex_rt_IF),
    .inst_rs (inst_IFID[RS_HI:RS_LO]),
    .inst_rt (inst_IFID[RT_HI:RT_LO]),
    .hazard  (hazard)
  );

  // Stall decision, bubble request and next FSM state; a redirect always returns to RUN
  always_comb begin
    state_nxt   = RUN;
    stall       = hazard && (state == RUN) && !redirect_IF;
    bubble_IFID = !rst_if_id && (stall || redirect_IF);
    if (stall) begin
      state_nxt = STALLED;
    end
  end

  // FSM state register
  always_ff @(posedge clk_if_id or posedge rst_if_id) begin
    if (rst_if_id) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // PC and IF/ID register: redirect flushes, stall holds, otherwise advance by one word
  always_ff @(posedge clk_if_id or posedge rst_if_id) begin
    if (rst_if_id) begin
      pc_IF         <= '0;
      nextInst_IFID <= '0;
      inst_IFID     <= NOP;
      valid_IFID    <= 1'b0;
    end else if (redirect_IF) begin
      pc_IF         <= {redirect_pc_IF[PC_W-1:2], 2'b00};
      nextInst_IFID <= '0;
      inst_IFID     <= NOP;
      valid_IFID    <= 1'b0;
    end else if (!stall) begin
      pc_IF         <= pc_plus4;
      nextInst_IFID <= pc_plus4;
      inst_IFID     <= imem_data_IF;
      valid_IFID    <= 1'b1;
    end
  end

  // Saturating event counters: stall cycles and redirect cycles, stick at all-ones
  always_ff @(posedge clk_if_id or posedge rst_if_id) begin
    if (rst_if_id) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && !(&stall_cnt_q)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (redirect_IF && !(&flush_cnt_q)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: fetch, load-use stall, zero-reg guard, redirect, wrap, saturation, async reset.
// Inputs driven after the falling edge, outputs sampled at the falling edge.
// Instruction memory is a combinational word array indexed by the PC.
module tb_if_id_stage;

  logic        clk_if_id;
  logic        rst_if_id;
  logic [7:0]  imem_addr_IF;
  logic [31:0] imem_data_IF;
  logic        redirect_IF;
  logic [7:0]  redirect_pc_IF;
  logic        idex_memread_IF;
  logic [4:0]  idex_rt_IF;
  logic [7:0]  pc_IF;
  logic [7:0]  nextInst_IFID;
  logic [31:0] inst_IFID;
  logic        valid_IFID;
  logic        bubble_IFID;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  logic [31:0] imem [0:63];
  int vectors;
  int miscompares;

  if_id_stage #(.PC_W(8), .CNT_W(16)) dut (
    .clk_if_id       (clk_if_id),
    .rst_if_id       (rst_if_id),
    .imem_addr_IF    (imem_addr_IF),
    .imem_data_IF    (imem_data_IF),
    .redirect_IF     (redirect_IF),
    .redirect_pc_IF  (redirect_pc_IF),
    .idex_memread_IF (idex_memread_IF),
    .idex_rt_IF      (idex_rt_IF),
    .pc_IF           (pc_IF),
    .nextInst_IFID   (nextInst_IFID),
    .inst_IFID       (inst_IFID),
    .valid_IFID      (valid_IFID),
    .bubble_IFID     (bubble_IFID),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  assign imem_data_IF = imem[imem_addr_IF[7:2]];

  initial begin
    clk_if_id = 1'b0;
    forever #5 clk_if_id = ~clk_if_id;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_if_id);
    @(negedge clk_if_id);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    // Filler words keep rs=rt=0 so they never alias a hazard
    for (int i = 0; i < 64; i++) imem[i] = 32'hFC00_0000 + i;
    imem[0]  = 32'h2008_0005;
    imem[1]  = 32'h2009_0003;   // rs=0, rt=9
    imem[2]  = 32'h0109_5020;   // rs=8, rt=9
    imem[17] = 32'h0109_5020;   // at 0x44

    rst_if_id       = 1'b1;
    redirect_IF     = 1'b1;     // must not raise bubble while in reset
    redirect_pc_IF  = 8'h00;
    idex_memread_IF = 1'b0;
    idex_rt_IF      = 5'd0;

    // Reset state
    @(negedge clk_if_id);
    check("rst_pc", 32'(pc_IF), 32'h0);
    check("rst_inst", inst_IFID, 32'h0);
    check("rst_next", 32'(nextInst_IFID), 32'h0);
    check("rst_valid", 32'(valid_IFID), 32'h0);
    check("rst_bubble", 32'(bubble_IFID), 32'h0);
    check("rst_cnts", {stall_cnt, flush_cnt}, 32'h0);
    redirect_IF = 1'b0;
    rst_if_id   = 1'b0;

    // Straight-line fetch
    step();
    check("f1_inst", inst_IFID, 32'h2008_0005);
    check("f1_next", 32'(nextInst_IFID), 32'h4);
    check("f1_valid", 32'(valid_IFID), 32'h1);
    step();
    check("f2_inst", inst_IFID, 32'h2009_0003);
    check("f2_next", 32'(nextInst_IFID), 32'h8);
    check("f2_pc", 32'(pc_IF), 32'h8);
    step();
    check("f3_inst", inst_IFID, 32'h0109_5020);
    check("f3_pc", 32'(pc_IF), 32'hC);

    // Load-use on rt=9: one held cycle, then STALLED lets it proceed
    idex_memread_IF = 1'b1;
    idex_rt_IF      = 5'd9;
    #1;
    check("lu_bubble", 32'(bubble_IFID), 32'h1);
    step();
    check("lu_pc_hold", 32'(pc_IF), 32'hC);
    check("lu_inst_hold", inst_IFID, 32'h0109_5020);
    check("lu_stall_cnt", 32'(stall_cnt), 32'h1);
    check("lu_guard_bubble", 32'(bubble_IFID), 32'h0);
    step();
    check("lu_go_pc", 32'(pc_IF), 32'h10);
    check("lu_go_inst", inst_IFID, 32'hFC00_0003);
    check("lu_go_cnt", 32'(stall_cnt), 32'h1);

    // Zero-register guard: load to $zero, instruction rt=0
    idex_rt_IF = 5'd0;
    #1;
    check("zr_bubble", 32'(bubble_IFID), 32'h0);
    step();
    check("zr_pc", 32'(pc_IF), 32'h14);
    check("zr_stall_cnt", 32'(stall_cnt), 32'h1);
    idex_memread_IF = 1'b0;

    // Redirect to 0x43 -> aligned 0x40
    redirect_IF    = 1'b1;
    redirect_pc_IF = 8'h43;
    #1;
    check("rd_bubble", 32'(bubble_IFID), 32'h1);
    step();
    check("rd_pc", 32'(pc_IF), 32'h40);
    check("rd_valid", 32'(valid_IFID), 32'h0);
    check("rd_inst", inst_IFID, 32'h0);
    check("rd_flush_cnt", 32'(flush_cnt), 32'h1);
    redirect_IF = 1'b0;
    step();
    check("rd_new_inst", inst_IFID, 32'hFC00_0010);
    check("rd_new_next", 32'(nextInst_IFID), 32'h44);
    step();
    check("rc_inst", inst_IFID, 32'h0109_5020);

    // Hazard on rs=8, then redirect in the same cycle wins
    idex_memread_IF = 1'b1;
    idex_rt_IF      = 5'd8;
    #1;
    check("rc_rs_bubble", 32'(bubble_IFID), 32'h1);
    redirect_IF    = 1'b1;
    redirect_pc_IF = 8'hF2;
    step();
    check("rc_pc", 32'(pc_IF), 32'hF0);
    check("rc_flush_cnt", 32'(flush_cnt), 32'h2);
    check("rc_stall_cnt", 32'(stall_cnt), 32'h1);
    redirect_IF     = 1'b0;
    idex_memread_IF = 1'b0;

    // Wrap: 0xF0 -> F4 -> F8 -> FC -> 00
    step();
    step();
    step();
    check("wr_pc_fc", 32'(pc_IF), 32'hFC);
    step();
    check("wr_pc", 32'(pc_IF), 32'h0);
    check("wr_next", 32'(nextInst_IFID), 32'h0);
    check("wr_inst", inst_IFID, 32'hFC00_003F);

    // Preset counters near all-ones
    force dut.stall_cnt_q = 16'hFFFE;
    force dut.flush_cnt_q = 16'hFFFE;
    #1;
    release dut.stall_cnt_q;
    release dut.flush_cnt_q;
    step();
    check("sat_inst_a", inst_IFID, 32'h2008_0005);
    idex_memread_IF = 1'b1;
    idex_rt_IF      = 5'd8;
    step();
    check("sat_stall_ffff", 32'(stall_cnt), 32'hFFFF);
    step();
    check("sat_inst_b", inst_IFID, 32'h2009_0003);
    idex_rt_IF = 5'd9;
    step();
    check("sat_stall_hold", 32'(stall_cnt), 32'hFFFF);
    check("sat_pc_hold", 32'(pc_IF), 32'h8);
    idex_memread_IF = 1'b0;
    redirect_IF     = 1'b1;
    redirect_pc_IF  = 8'h10;
    step();
    check("sat_flush_ffff", 32'(flush_cnt), 32'hFFFF);
    step();
    check("sat_flush_hold", 32'(flush_cnt), 32'hFFFF);
    redirect_IF = 1'b0;
    step();
    check("pre_rst_inst", inst_IFID, 32'hFC00_0004);

    // Asynchronous reset mid-cycle, with a hazard pending
    idex_memread_IF = 1'b1;
    #2;
    rst_if_id = 1'b1;
    #1;
    check("ar_pc", 32'(pc_IF), 32'h0);
    check("ar_inst", inst_IFID, 32'h0);
    check("ar_next", 32'(nextInst_IFID), 32'h0);
    check("ar_valid", 32'(valid_IFID), 32'h0);
    check("ar_cnts", {stall_cnt, flush_cnt}, 32'h0);
    check("ar_bubble", 32'(bubble_IFID), 32'h0);
    idex_memread_IF = 1'b0;
    @(negedge clk_if_id);
    rst_if_id = 1'b0;
    step();
    check("ar_refetch", inst_IFID, 32'h2008_0005);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
